// File: rtl/axi_slave_mem.sv
// Behavioural AXI4 slave memory: single-outstanding INCR/FIXED bursts served
// from a word array whose word i reads back as i until it is first written.
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                s_aclk,
    input  logic                s_aresetn,
    // read address
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    // write address
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    // write data
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [15:0] RD_END = 16'(RD_LATENCY - 1);
    localparam logic [15:0] WR_END = 16'(WR_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_WAIT, WR_RESP
    } state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   rid_q, bid_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [7:0]            len_q;
    logic                  fixed_q, err_q;
    logic [8:0]            beat_q;
    logic [15:0]           lat_q;
    logic [1:0]            bresp_q;

    // Words are stored XOR-ed with their own index, so a zero power-up
    // image reads back as word i = i without any load sequence.
    logic [31:0]           mem [DEPTH];
    logic [31:0]           key, rd_word;

    logic ar_hs, aw_hs, r_hs, w_hs, last_beat;
    logic unused_addr;

    assign key       = 32'(idx_q);
    assign rd_word   = mem[idx_q] ^ key;
    assign last_beat = (beat_q == {1'b0, len_q});

    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign r_hs  = s_axi_rvalid & s_axi_rready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;

    assign s_axi_rid   = rid_q;
    assign s_axi_bid   = bid_q;
    assign s_axi_rdata = (state == RD_BURST) ? rd_word : '0;
    assign s_axi_rlast = (state == RD_BURST) & last_beat;
    assign s_axi_rresp = (state == RD_BURST && err_q) ? 2'b10 : 2'b00;
    assign s_axi_bresp = s_axi_bvalid ? bresp_q : 2'b00;

    // Only the word-index bits of the byte address select storage.
    assign unused_addr = ^{s_axi_araddr[31:ADDR_WIDTH+2], s_axi_araddr[1:0],
                           s_axi_awaddr[31:ADDR_WIDTH+2], s_axi_awaddr[1:0]};

    // State register.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state and handshake outputs; write wins a same-cycle AR/AW race.
    always_comb begin
        state_nxt     = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (state)
            IDLE: begin
                s_axi_awready = s_axi_awvalid & s_aresetn;
                s_axi_arready = s_axi_arvalid & ~s_axi_awvalid & s_aresetn;
                if (s_axi_awvalid)
                    state_nxt = WR_DATA;
                else if (s_axi_arvalid)
                    state_nxt = (RD_LATENCY == 0) ? RD_BURST : RD_WAIT;
            end
            RD_WAIT:  if (lat_q == RD_END) state_nxt = RD_BURST;
            RD_BURST: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && last_beat) state_nxt = IDLE;
            end
            WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast)
                    state_nxt = (WR_LATENCY == 0) ? WR_RESP : WR_WAIT;
            end
            WR_WAIT:  if (lat_q == WR_END) state_nxt = WR_RESP;
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Burst context: latched on address handshake, advanced per data beat.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            rid_q   <= '0;
            bid_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            lat_q   <= '0;
            bresp_q <= 2'b00;
        end else begin
            if ((state == RD_WAIT || state == WR_WAIT) && state_nxt == state)
                lat_q <= lat_q + 16'd1;
            else
                lat_q <= '0;
            if (ar_hs) begin
                rid_q   <= s_axi_arid;
                idx_q   <= s_axi_araddr[ADDR_WIDTH+1:2];
                len_q   <= s_axi_arlen;
                fixed_q <= (s_axi_arburst == 2'b00);
                err_q   <= (s_axi_arsize != 3'b010);
                beat_q  <= '0;
            end
            if (aw_hs) begin
                bid_q   <= s_axi_awid;
                idx_q   <= s_axi_awaddr[ADDR_WIDTH+1:2];
                len_q   <= s_axi_awlen;
                fixed_q <= (s_axi_awburst == 2'b00);
                err_q   <= (s_axi_awsize != 3'b010);
                beat_q  <= '0;
            end
            if (r_hs || w_hs) begin
                beat_q <= beat_q + 9'd1;
                if (!fixed_q) idx_q <= idx_q + ADDR_WIDTH'(1);
            end
            // A short or long burst (wlast off the len+1 beat) is flagged.
            if (w_hs && s_axi_wlast)
                bresp_q <= (err_q || !last_beat) ? 2'b10 : 2'b00;
        end
    end

    // Byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge s_aclk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++)
                if (s_axi_wstrb[i])
                    mem[idx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8] ^ key[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised scoreboard bench for axi_slave_mem against a word-array model.
module tb_axi_slave_mem;

    localparam int AW = 16;
    localparam int IDW = 4;
    localparam int RDL = 2;
    localparam int WRL = 1;
    localparam int DEPTH = 1 << AW;

    logic clk, rst_n;
    logic [IDW-1:0] arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0] wstrb;

    axi_slave_mem #(.ADDR_WIDTH(AW), .ID_WIDTH(IDW), .RD_LATENCY(RDL),
                    .WR_LATENCY(WRL)) dut (
        .s_aclk(clk), .s_aresetn(rst_n),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } r_exp_t;
    typedef struct { logic [1:0] resp; logic [IDW-1:0] id; } b_exp_t;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    r_exp_t mon_r;
    b_exp_t mon_b;
    logic [31:0] mdl [int unsigned];
    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];
    int n_chk = 0, n_fail = 0;
    int rready_mode = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void tmo(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endfunction

    function automatic logic [31:0] mdl_word(input int unsigned idx);
        if (mdl.exists(idx)) return mdl[idx];
        return idx;
    endfunction

    // Read-data driver: always ready, toggling, or random.
    initial begin
        rready = 1;
        forever begin
            @(posedge clk); #1;
            case (rready_mode)
                0: rready = 1;
                1: rready = ~rready;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: each cycle a response is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (exp_r.size() == 0) tmo("r_unexpected_beat");
            else begin
                mon_r = exp_r[0];
                chk("rdata", rdata, mon_r.data);
                chk("rresp", 32'(rresp), 32'(mon_r.resp));
                chk("rlast", 32'(rlast), 32'(mon_r.last));
                chk("rid", 32'(rid), 32'(mon_r.id));
                if (rready) void'(exp_r.pop_front());
            end
        end
        if (rst_n && bvalid) begin
            if (exp_b.size() == 0) tmo("b_unexpected_resp");
            else begin
                mon_b = exp_b[0];
                chk("bresp", 32'(bresp), 32'(mon_b.resp));
                chk("bid", 32'(bid), 32'(mon_b.id));
                if (bready) void'(exp_b.pop_front());
            end
        end
    end

    task automatic model_read(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                              input logic [2:0] sz, input logic [IDW-1:0] id);
        int unsigned idx;
        r_exp_t e;
        idx = (a >> 2) % DEPTH;
        for (int b = 0; b <= int'(l); b++) begin
            e.data = mdl_word(idx);
            e.resp = (sz != 3'd2) ? 2'b10 : 2'b00;
            e.last = (b == int'(l));
            e.id   = id;
            exp_r.push_back(e);
            if (bu != 2'b00) idx = (idx + 1) % DEPTH;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                               input logic [2:0] sz, input logic [IDW-1:0] id, input int nb);
        int unsigned idx;
        logic [31:0] w;
        b_exp_t e;
        idx = (a >> 2) % DEPTH;
        for (int b = 0; b < nb; b++) begin
            w = mdl_word(idx);
            for (int k = 0; k < 4; k++)
                if (wq_strb[b][k]) w[8*k +: 8] = wq_data[b][8*k +: 8];
            mdl[idx] = w;
            if (bu != 2'b00) idx = (idx + 1) % DEPTH;
        end
        e.resp = (sz != 3'd2 || nb != int'(l) + 1) ? 2'b10 : 2'b00;
        e.id = id;
        exp_b.push_back(e);
    endtask

    task automatic ar_issue(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                            input logic [2:0] sz, input logic [IDW-1:0] id);
        int t = 0;
        araddr = a; arlen = l; arburst = bu; arsize = sz; arid = id; arvalid = 1;
        @(negedge clk);
        while (!arready && t < 100) begin t++; @(negedge clk); end
        if (!arready) tmo("ar_handshake");
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic aw_issue(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                            input logic [2:0] sz, input logic [IDW-1:0] id);
        int t = 0;
        awaddr = a; awlen = l; awburst = bu; awsize = sz; awid = id; awvalid = 1;
        @(negedge clk);
        while (!awready && t < 100) begin t++; @(negedge clk); end
        if (!awready) tmo("aw_handshake");
        @(posedge clk); #1;
        awvalid = 0;
    endtask

    task automatic w_send(input int nb, input bit gaps);
        int t;
        for (int b = 0; b < nb; b++) begin
            wvalid = 1; wdata = wq_data[b]; wstrb = wq_strb[b]; wlast = (b == nb - 1);
            t = 0;
            @(negedge clk);
            while (!wready && t < 100) begin t++; @(negedge clk); end
            if (!wready) tmo("w_handshake");
            @(posedge clk); #1;
            wvalid = 0; wlast = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_r_done();
        int t = 0;
        while (exp_r.size() != 0 && t < 4000) begin @(negedge clk); t++; end
        if (exp_r.size() != 0) begin tmo("r_burst_complete"); exp_r.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic wait_b_done();
        int t = 0;
        while (exp_b.size() != 0 && t < 200) begin @(negedge clk); t++; end
        if (exp_b.size() != 0) begin tmo("b_complete"); exp_b.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                           input logic [2:0] sz, input logic [IDW-1:0] id);
        int c = 0;
        model_read(a, l, bu, sz, id);
        ar_issue(a, l, bu, sz, id);
        do begin @(negedge clk); c++; end while (!rvalid && c < 50);
        chk("rd_latency", c, RDL + 1);
        wait_r_done();
    endtask

    // Caller fills wq_data/wq_strb with nb beats first.
    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                            input logic [2:0] sz, input logic [IDW-1:0] id, input int nb,
                            input int bhold, input bit gaps);
        int t = 0;
        model_write(a, l, bu, sz, id, nb);
        bready = (bhold == 0);
        aw_issue(a, l, bu, sz, id);
        w_send(nb, gaps);
        if (bhold > 0) begin
            @(negedge clk);
            while (!bvalid && t < 100) begin t++; @(negedge clk); end
            for (int i = 0; i < bhold; i++) begin
                chk("bvalid_held", 32'(bvalid), 1);
                @(negedge clk);
            end
            @(posedge clk); #1;
            bready = 1;
        end
        wait_b_done();
    endtask

    task automatic fill_w(input int nb, input logic [31:0] base, input bit rnd, input logic [3:0] strb);
        wq_data.delete();
        wq_strb.delete();
        for (int i = 0; i < nb; i++) begin
            wq_data.push_back(rnd ? $urandom() : base + 32'(i));
            wq_strb.push_back(rnd ? 4'($urandom_range(0, 15)) : strb);
        end
    endtask

    logic [31:0] r_a;
    logic [7:0]  r_l;
    logic [1:0]  r_bu;
    logic [2:0]  r_sz;
    logic [IDW-1:0] r_id;
    int r_nb;

    initial begin
        rst_n = 0;
        arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; bready = 1;
        araddr = 0; arlen = 0; arsize = 0; arburst = 0; arid = 0;
        awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awid = 0;
        wdata = 0; wstrb = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_handshakes", 32'({arready, awready, rvalid, wready, bvalid}), 0);
        chk("rst_rlast_resp", 32'({rlast, rresp, bresp}), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids", 32'({rid, bid}), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Preloaded words 16..19.
        do_read(32'h40, 8'd3, 2'b01, 3'd2, 4'h5);

        // Write then read back.
        fill_w(4, 32'hA0, 0, 4'hF);
        do_write(32'h100, 8'd3, 2'b01, 3'd2, 4'h3, 4, 0, 0);
        do_read(32'h100, 8'd3, 2'b01, 3'd2, 4'h9);

        // Byte strobes on word 2: expect 0x00220044.
        fill_w(1, 32'h11223344, 0, 4'b0101);
        do_write(32'h8, 8'd0, 2'b01, 3'd2, 4'h1, 1, 0, 0);
        do_read(32'h8, 8'd0, 2'b01, 3'd2, 4'h1);

        // Backpressure on R and on B.
        rready_mode = 1;
        do_read(32'h1000, 8'd7, 2'b01, 3'd2, 4'hC);
        rready_mode = 0;
        fill_w(2, 0, 1, 4'h0);
        do_write(32'h300, 8'd1, 2'b01, 3'd2, 4'h6, 2, 5, 0);

        // Same-cycle AR and AW: write first, read sees the new data.
        fill_w(2, 32'hBEEF0000, 0, 4'hF);
        model_write(32'h200, 8'd1, 2'b01, 3'd2, 4'h2, 2);
        model_read(32'h200, 8'd1, 2'b01, 3'd2, 4'h4);
        awaddr = 32'h200; awlen = 1; awburst = 2'b01; awsize = 2; awid = 4'h2; awvalid = 1;
        araddr = 32'h200; arlen = 1; arburst = 2'b01; arsize = 2; arid = 4'h4; arvalid = 1;
        @(negedge clk);
        chk("both_awready", 32'(awready), 1);
        chk("both_arready", 32'(arready), 0);
        @(posedge clk); #1;
        awvalid = 0;
        w_send(2, 0);
        begin
            int t = 0;
            @(negedge clk);
            while (!arready && t < 100) begin t++; @(negedge clk); end
            chk("read_after_b", 32'(exp_b.size()), 0);
        end
        @(posedge clk); #1;
        arvalid = 0;
        wait_r_done();

        // Early wlast, bad sizes, wrap, FIXED.
        fill_w(3, 32'hC0, 0, 4'hF);
        do_write(32'h400, 8'd3, 2'b01, 3'd2, 4'h7, 3, 0, 0);
        fill_w(2, 32'hD0, 0, 4'hF);
        do_write(32'h500, 8'd1, 2'b01, 3'd0, 4'h8, 2, 0, 0);
        do_read(32'h400, 8'd3, 2'b01, 3'd1, 4'hA);
        do_read(32'hFFFF_FFFC, 8'd3, 2'b01, 3'd2, 4'hB);
        do_read(32'h104, 8'd3, 2'b00, 3'd2, 4'hD);
        do_read(32'h3F0, 8'd255, 2'b01, 3'd2, 4'hE);

        // Random mix.
        for (int n = 0; n < 40; n++) begin
            r_a  = $urandom();
            if ($urandom_range(0, 1) == 1) r_a = r_a & 32'hFFFC_00FC;
            r_l  = 8'($urandom_range(0, 15));
            r_bu = 2'($urandom_range(0, 3));
            r_sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            r_id = 4'($urandom_range(0, 15));
            rready_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                r_nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, int'(r_l) + 2) : int'(r_l) + 1;
                fill_w(r_nb, 0, 1, 4'h0);
                do_write(r_a, r_l, r_bu, r_sz, r_id, r_nb, $urandom_range(0, 3), 1);
            end else begin
                do_read(r_a, r_l, r_bu, r_sz, r_id);
            end
        end
        rready_mode = 0;

        // Reset in the middle of a read burst.
        model_read(32'h100, 8'd7, 2'b01, 3'd2, 4'h3);
        ar_issue(32'h100, 8'd7, 2'b01, 3'd2, 4'h3);
        begin
            int t = 0;
            while (exp_r.size() > 5 && t < 100) begin @(negedge clk); t++; end
        end
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_rlast_rresp", 32'({rlast, rresp}), 0);
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        // Contents survive reset; AR is accepted straight away from IDLE.
        do_read(32'h100, 8'd3, 2'b01, 3'd2, 4'h3);

        repeat (3) @(posedge clk);
        chk("r_queue_empty", 32'(exp_r.size()), 0);
        chk("b_queue_empty", 32'(exp_b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        tmo("watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
